// File: rtl/riscv_core_run_ctrl_if.sv
// Register-block <-> run-controller bundle. The master side is the AXI-Lite register block;
// the slave side is riscv_core_run_ctrl. i_core_halt exists only with RISCV_HALT_DETECT_EN.
interface riscv_core_run_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int IMEM_AW    = 10,
  parameter int CNT_WIDTH  = 32
);
  logic                  i_run;
  logic [CNT_WIDTH-1:0]  i_num_cycle;
  logic                  i_mem_reset_n;
  logic                  i_instr_write;
  logic [DATA_WIDTH-1:0] i_instr_addr;
  logic [DATA_WIDTH-1:0] i_instr_data;
`ifdef RISCV_HALT_DETECT_EN
  logic                  i_core_halt;
`endif
  logic                  o_idle;
  logic                  o_running;
  logic                  o_done;
  logic                  o_core_rst_n;
  logic                  o_core_en;
  logic                  o_imem_we;
  logic [IMEM_AW-1:0]    o_imem_addr;
  logic [DATA_WIDTH-1:0] o_imem_wdata;
  logic [CNT_WIDTH-1:0]  o_cycle_cnt;
  logic                  o_wr_drop;
  logic [1:0]            state_dbg;

`ifdef RISCV_HALT_DETECT_EN
  modport master (
    output i_run, i_num_cycle, i_mem_reset_n, i_instr_write, i_instr_addr, i_instr_data, i_core_halt,
    input  o_idle, o_running, o_done, o_core_rst_n, o_core_en, o_imem_we, o_imem_addr,
           o_imem_wdata, o_cycle_cnt, o_wr_drop, state_dbg
  );
  modport slave (
    input  i_run, i_num_cycle, i_mem_reset_n, i_instr_write, i_instr_addr, i_instr_data, i_core_halt,
    output o_idle, o_running, o_done, o_core_rst_n, o_core_en, o_imem_we, o_imem_addr,
           o_imem_wdata, o_cycle_cnt, o_wr_drop, state_dbg
  );
`else
  modport master (
    output i_run, i_num_cycle, i_mem_reset_n, i_instr_write, i_instr_addr, i_instr_data,
    input  o_idle, o_running, o_done, o_core_rst_n, o_core_en, o_imem_we, o_imem_addr,
           o_imem_wdata, o_cycle_cnt, o_wr_drop, state_dbg
  );
  modport slave (
    input  i_run, i_num_cycle, i_mem_reset_n, i_instr_write, i_instr_addr, i_instr_data,
    output o_idle, o_running, o_done, o_core_rst_n, o_core_en, o_imem_we, o_imem_addr,
           o_imem_wdata, o_cycle_cnt, o_wr_drop, state_dbg
  );
`endif
endinterface

// File: rtl/riscv_core_run_ctrl.sv
// Run sequencer for the RISC-V core: imem loading, core reset hold, fixed-length run, status.
// Optional RISCV_HALT_DETECT_EN adds i_core_halt, which ends a run early.
module riscv_core_run_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int IMEM_AW    = 10,
  parameter int CNT_WIDTH  = 32,
  parameter int RST_HOLD   = 4
) (
  input logic                  S_AXI_ACLK,
  input logic                  S_AXI_ARESET,
  riscv_core_run_ctrl_if.slave bus
);
  // Handshake: i_run is a one-cycle tick, taken only in IDLE with i_mem_reset_n high; an imem write
  // is requested by a 0->1 edge of the i_instr_write level and acknowledged by a one-cycle o_imem_we.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);

  state_t                state;
  state_t                state_nx;
  logic [HW-1:0]         hold_cnt;
  logic [CNT_WIDTH-1:0]  num_cycle;
  logic [CNT_WIDTH-1:0]  cycle_cnt;
  logic [CNT_WIDTH:0]    cnt_next_ext;
  logic                  core_rst_n;
  logic                  instr_write_q;
  logic                  wr_drop;
  logic                  imem_we;
  logic [IMEM_AW-1:0]    imem_addr;
  logic [DATA_WIDTH-1:0] imem_wdata;
  logic                  run_ok;
  logic                  abort;
  logic                  wr_edge;
  logic                  wr_ok;
  logic                  last_cycle;
  logic                  halt;
  logic                  unused_addr_bits;

  assign run_ok       = bus.i_run & bus.i_mem_reset_n;
  assign abort        = ~bus.i_mem_reset_n;
  assign wr_edge      = bus.i_instr_write & ~instr_write_q;
  assign wr_ok        = (state == ST_IDLE) & bus.i_mem_reset_n;
  assign cnt_next_ext = {1'b0, cycle_cnt} + {{CNT_WIDTH{1'b0}}, 1'b1};
  // Full-width unsigned compare: the cycle being executed now is the last one.
  assign last_cycle   = cnt_next_ext >= {1'b0, num_cycle};

`ifdef RISCV_HALT_DETECT_EN
  assign halt = bus.i_core_halt;
`else
  assign halt = 1'b0;
`endif

  assign unused_addr_bits = ^{bus.i_instr_addr[DATA_WIDTH-1:IMEM_AW+2], bus.i_instr_addr[1:0]};

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) state <= ST_IDLE;
    else              state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (run_ok) state_nx = ST_HOLD;
      end
      ST_HOLD: begin
        if (abort)                      state_nx = ST_IDLE;
        else if (hold_cnt == HOLD_LAST) state_nx = (num_cycle == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        if (abort)                    state_nx = ST_IDLE;
        else if (last_cycle || halt)  state_nx = ST_DONE;
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      hold_cnt      <= '0;
      num_cycle     <= '0;
      cycle_cnt     <= '0;
      core_rst_n    <= 1'b0;
      instr_write_q <= 1'b0;
      wr_drop       <= 1'b0;
      imem_we       <= 1'b0;
      imem_addr     <= '0;
      imem_wdata    <= '0;
    end else begin
      instr_write_q <= bus.i_instr_write;
      imem_we       <= 1'b0;

      if (wr_edge) begin
        if (wr_ok) begin
          imem_we    <= 1'b1;
          imem_addr  <= bus.i_instr_addr[IMEM_AW+1:2];
          imem_wdata <= bus.i_instr_data;
        end else begin
          wr_drop <= 1'b1;
        end
      end

      case (state)
        ST_IDLE: begin
          if (run_ok) begin
            num_cycle <= bus.i_num_cycle;
            cycle_cnt <= '0;
            hold_cnt  <= '0;
            wr_drop   <= 1'b0;
          end
        end
        ST_HOLD: hold_cnt <= hold_cnt + {{(HW-1){1'b0}}, 1'b1};
        // The abort cycle still had the core enabled, so it is counted like any other RUN cycle.
        ST_RUN: begin
          if (cycle_cnt != '1) cycle_cnt <= cnt_next_ext[CNT_WIDTH-1:0];
        end
        default: ;
      endcase

      // Core leaves reset only for RUN; after a completed run it stays out of reset so its state is readable.
      if (state_nx == ST_RUN)
        core_rst_n <= 1'b1;
      else if (state_nx == ST_HOLD)
        core_rst_n <= 1'b0;
      else if (abort && (state == ST_HOLD || state == ST_RUN))
        core_rst_n <= 1'b0;
    end
  end

  assign bus.o_idle       = (state == ST_IDLE);
  assign bus.o_running    = (state == ST_HOLD) || (state == ST_RUN);
  assign bus.o_done       = (state == ST_DONE);
  assign bus.o_core_en    = (state == ST_RUN);
  assign bus.o_core_rst_n = core_rst_n;
  assign bus.o_imem_we    = imem_we;
  assign bus.o_imem_addr  = imem_addr;
  assign bus.o_imem_wdata = imem_wdata;
  assign bus.o_cycle_cnt  = cycle_cnt;
  assign bus.o_wr_drop    = wr_drop;
  assign bus.state_dbg    = state;
endmodule

// File: tb/tb_riscv_core_run_ctrl.sv
// Bench for riscv_core_run_ctrl: timeline model of each run plus an imem write scoreboard,
// directed scenarios with literal expectations, then randomized traffic.
module tb_riscv_core_run_ctrl;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int CW = 32;
  localparam int RH = 4;
  localparam int W  = AW + DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  riscv_core_run_ctrl_if #(.DATA_WIDTH(DW), .IMEM_AW(AW), .CNT_WIDTH(CW)) bus();

  riscv_core_run_ctrl #(.DATA_WIDTH(DW), .IMEM_AW(AW), .CNT_WIDTH(CW), .RST_HOLD(RH)) dut (
    .S_AXI_ACLK  (clk),
    .S_AXI_ARESET(rst),
    .bus         (bus)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Model: a run is a timeline anchored at the i_run cycle (offset 0).
  longint  cyc;
  bit      m_active;
  longint  m_t0;
  longint  m_n;
  bit      e_idle, e_running, e_done, e_en, e_rst, e_drop;
  logic [CW-1:0] e_cnt;
  bit      prev_wr;
  logic [W-1:0] exp_q[$];

  int      obs_en, obs_done, obs_rstlow;
  longint  obs_done_cyc;
  longint  run_cyc;
  logic [AW-1:0] obs_waddr[$];
  logic [DW-1:0] obs_wdata[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_t0 = 0; m_n = 0;
    e_idle = 1'b1; e_running = 1'b0; e_done = 1'b0; e_en = 1'b0; e_rst = 1'b0; e_drop = 1'b0;
    e_cnt = '0;
    prev_wr = 1'b0;
    exp_q.delete();
  endtask

  task automatic clear_obs();
    obs_en = 0; obs_done = 0; obs_rstlow = 0; obs_done_cyc = -1;
    obs_waddr.delete(); obs_wdata.delete();
  endtask

  // Advances the model across the coming clock edge using the inputs currently applied.
  task automatic model_edge();
    bit     wr_edge;
    bit     prev_running;
    bit     prev_en;
    longint off;
    longint k;
    cyc++;
    prev_running = e_running;
    prev_en      = e_en;
    wr_edge = bus.i_instr_write && !prev_wr;
    prev_wr = bus.i_instr_write;
    if (wr_edge) begin
      if (e_idle && bus.i_mem_reset_n) exp_q.push_back({bus.i_instr_addr[AW+1:2], bus.i_instr_data});
      else e_drop = 1'b1;
    end
    if (e_idle && bus.i_run && bus.i_mem_reset_n) begin
      m_active = 1'b1;
      m_t0     = cyc - 1;
      m_n      = {32'b0, bus.i_num_cycle};
      e_drop   = 1'b0;
      e_cnt    = '0;
    end
`ifdef RISCV_HALT_DETECT_EN
    else if (m_active && prev_en && bus.i_core_halt && bus.i_mem_reset_n) begin
      m_n = (cyc - 1 - m_t0) - RH;
    end
`endif
    e_running = 1'b0; e_en = 1'b0; e_done = 1'b0;
    if (m_active) begin
      off = cyc - m_t0;
      if (off > RH) begin
        k = off - 1 - RH;
        e_cnt = 32'((k > m_n) ? m_n : k);
      end
      if (prev_running && !bus.i_mem_reset_n) begin
        m_active = 1'b0;
        e_rst    = 1'b0;
      end else begin
        e_running = (off >= 1) && (off <= RH + m_n);
        e_en      = (off > RH) && (off <= RH + m_n);
        e_done    = (off == RH + m_n + 1);
        if (off >= 1 && off <= RH) e_rst = 1'b0;
        if (e_en) e_rst = 1'b1;
        if (e_done) m_active = 1'b0;
      end
    end
    e_idle = !e_running && !e_done;
  endtask

  task automatic compare_outputs();
    logic [W-1:0] w;
    check("idle",       64'(bus.o_idle),       64'(e_idle));
    check("running",    64'(bus.o_running),    64'(e_running));
    check("done",       64'(bus.o_done),       64'(e_done));
    check("core_en",    64'(bus.o_core_en),    64'(e_en));
    check("core_rst_n", 64'(bus.o_core_rst_n), 64'(e_rst));
    check("cycle_cnt",  64'(bus.o_cycle_cnt),  64'(e_cnt));
    check("wr_drop",    64'(bus.o_wr_drop),    64'(e_drop));
    check("imem_we",    64'(bus.o_imem_we),    64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      w = exp_q.pop_front();
      if (bus.o_imem_we) begin
        check("imem_addr",  64'(bus.o_imem_addr),  64'(w[W-1:DW]));
        check("imem_wdata", 64'(bus.o_imem_wdata), 64'(w[DW-1:0]));
      end
    end
    if (bus.o_core_en) obs_en++;
    if (bus.o_done) begin obs_done++; obs_done_cyc = cyc; end
    if (bus.o_running && !bus.o_core_rst_n) obs_rstlow++;
    if (bus.o_imem_we) begin obs_waddr.push_back(bus.o_imem_addr); obs_wdata.push_back(bus.o_imem_wdata); end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic do_write(input logic [DW-1:0] addr, input logic [DW-1:0] data);
    bus.i_instr_addr = addr; bus.i_instr_data = data; bus.i_instr_write = 1'b1;
    step();
    bus.i_instr_write = 1'b0;
    step();
  endtask

  task automatic start_run(input logic [CW-1:0] n);
    run_cyc = cyc + 1;
    bus.i_run = 1'b1; bus.i_num_cycle = n;
    step();
    bus.i_run = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    step();
    for (int i = 0; i < max && !bus.o_idle; i++) step();
    check("idle_reached", 64'(bus.o_idle), 64'd1);
  endtask

  initial begin
    cyc = 0;
    bus.i_run = 1'b0; bus.i_num_cycle = '0; bus.i_mem_reset_n = 1'b1; bus.i_instr_write = 1'b0;
    bus.i_instr_addr = '0; bus.i_instr_data = '0;
`ifdef RISCV_HALT_DETECT_EN
    bus.i_core_halt = 1'b0;
`endif
    model_reset();
    clear_obs();
    repeat (2) @(posedge clk);
    #1;
    check("rst_idle",    64'(bus.o_idle),       64'd1);
    check("rst_running", 64'(bus.o_running),    64'd0);
    check("rst_rst_n",   64'(bus.o_core_rst_n), 64'd0);
    check("rst_cnt",     64'(bus.o_cycle_cnt),  64'd0);
    check("rst_we",      64'(bus.o_imem_we),    64'd0);
    rst = 1'b0;
    step(); step();

    // Two imem writes in IDLE
    clear_obs();
    do_write(32'h0, 32'h0050_0093);
    do_write(32'h4, 32'h0010_0113);
    check("wr_count", 64'(obs_waddr.size()), 64'd2);
    if (obs_waddr.size() == 2) begin
      check("wr0_addr", 64'(obs_waddr[0]), 64'd0);
      check("wr1_addr", 64'(obs_waddr[1]), 64'd1);
      check("wr0_data", 64'(obs_wdata[0]), 64'h0050_0093);
      check("wr1_data", 64'(obs_wdata[1]), 64'h0010_0113);
    end

    // N=5 run
    clear_obs();
    start_run(32'd5);
    wait_idle(40);
    check("n5_en_cycles", 64'(obs_en),      64'd5);
    check("n5_done_once", 64'(obs_done),    64'd1);
    check("n5_rst_low",   64'(obs_rstlow),  64'd4);
    check("n5_cnt",       64'(bus.o_cycle_cnt), 64'd5);
    check("n5_done_lat",  64'(obs_done_cyc - run_cyc), 64'd9);
    check("n5_rst_n_kept", 64'(bus.o_core_rst_n), 64'd1);

    // N=0 run: reset hold then straight to done
    clear_obs();
    start_run(32'd0);
    wait_idle(40);
    check("n0_en_cycles", 64'(obs_en),   64'd0);
    check("n0_done_once", 64'(obs_done), 64'd1);
    check("n0_done_lat",  64'(obs_done_cyc - run_cyc), 64'd4);
    check("n0_cnt",       64'(bus.o_cycle_cnt), 64'd0);

    // Same-cycle run and write edge: both taken
    clear_obs();
    run_cyc = cyc + 1;
    bus.i_run = 1'b1; bus.i_num_cycle = 32'd2;
    bus.i_instr_write = 1'b1; bus.i_instr_addr = 32'h8; bus.i_instr_data = 32'hDEAD_BEEF;
    step();
    bus.i_run = 1'b0; bus.i_instr_write = 1'b0;
    wait_idle(40);
    check("same_wr_count", 64'(obs_waddr.size()), 64'd1);
    check("same_done",     64'(obs_done), 64'd1);
    check("same_drop",     64'(bus.o_wr_drop), 64'd0);

    // Abort during RUN cycle 3 of 10, with a write edge dropped during RUN
    clear_obs();
    start_run(32'd10);
    repeat (5) step();
    bus.i_instr_write = 1'b1;
    step();
    bus.i_instr_write = 1'b0;
    bus.i_mem_reset_n = 1'b0;
    step();
    bus.i_mem_reset_n = 1'b1;
    repeat (3) step();
    check("abort_no_done", 64'(obs_done), 64'd0);
    check("abort_cnt",     64'(bus.o_cycle_cnt), 64'd3);
    check("abort_drop",    64'(bus.o_wr_drop), 64'd1);
    check("abort_no_we",   64'(obs_waddr.size()), 64'd0);
    check("abort_rst_n",   64'(bus.o_core_rst_n), 64'd0);
    check("abort_idle",    64'(bus.o_idle), 64'd1);

`ifdef RISCV_HALT_DETECT_EN
    // Halt at RUN cycle 7 of 50
    clear_obs();
    start_run(32'd50);
    repeat (RH + 6) step();
    bus.i_core_halt = 1'b1;
    step();
    bus.i_core_halt = 1'b0;
    step();
    check("halt_done", 64'(obs_done), 64'd1);
    check("halt_cnt",  64'(bus.o_cycle_cnt), 64'd7);
    wait_idle(10);
`endif

    // Reset mid-run at cnt=40
    start_run(32'd100);
    for (int i = 0; i < 200 && bus.o_cycle_cnt != 32'd40; i++) step();
    check("cnt40_reached", 64'(bus.o_cycle_cnt), 64'd40);
    rst = 1'b1;
    #1;
    check("mid_rst_idle",    64'(bus.o_idle),       64'd1);
    check("mid_rst_running", 64'(bus.o_running),    64'd0);
    check("mid_rst_en",      64'(bus.o_core_en),    64'd0);
    check("mid_rst_rst_n",   64'(bus.o_core_rst_n), 64'd0);
    check("mid_rst_cnt",     64'(bus.o_cycle_cnt),  64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bus.i_run         = ($urandom_range(0, 15) == 0);
      bus.i_num_cycle   = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 12));
      bus.i_mem_reset_n = ($urandom_range(0, 39) != 0);
      bus.i_instr_write = ($urandom_range(0, 1) == 1);
      bus.i_instr_addr  = $urandom;
      bus.i_instr_data  = $urandom;
`ifdef RISCV_HALT_DETECT_EN
      bus.i_core_halt   = ($urandom_range(0, 29) == 0);
`endif
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
